// File: rtl/l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_request_arbiter
// Purpose  : Arbitrates L2 access between demand misses/write-backs and
//            prefetch-buffer installs, capping consecutive demand grants.
//            Prefetch path compiled in only with L2_ARB_PREFETCH_EN.
// Revision : 1.0  initial release
// ============================================================================
module l2_request_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         dem_read,
   input  logic         dem_write,
   input  logic [15:0]  dem_address,
   input  logic [127:0] dem_wdata,
   output logic         dem_resp,
   output logic [127:0] dem_rdata,
   input  logic         pf_ready,
   input  logic [15:0]  pf_address,
   input  logic [127:0] pf_wdata,
   output logic         pf_ack,
   output logic         l2_read,
   output logic         l2_write,
   output logic [15:0]  l2_address,
   output logic [127:0] l2_wdata,
   input  logic         l2_resp,
   input  logic [127:0] l2_rdata,
   output logic         dont_prefetch
);

`ifdef L2_ARB_PREFETCH_EN
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEMAND   = 2'd1,
      ST_PREFETCH = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEMAND   = 2'd1
   } state_t;
`endif

   state_t         r_state;
   state_t         w_state_next;
   logic           r_op_write;
   logic [15:0]    r_addr;
   logic [127:0]   r_wdata;
   logic           w_idle;
   logic           w_dem_pending;
   logic           w_grant_dem;

   assign w_idle        = (r_state == ST_IDLE);
   assign w_dem_pending = dem_read | dem_write;

`ifdef L2_ARB_PREFETCH_EN
   localparam int                  c_cnt_w      = $clog2(STARVE_LIMIT + 2);
   localparam logic [c_cnt_w-1:0]  c_starve_max = c_cnt_w'(STARVE_LIMIT);

   logic [c_cnt_w-1:0] r_starve;
   logic               w_starved;
   logic               w_grant_pf;

   // Starvation only matters while a prefetch is actually waiting; this also
   // keeps a zero limit from blocking demand when pf_ready is low.
   assign w_starved   = pf_ready & (r_starve == c_starve_max);
   assign w_grant_dem = w_idle & w_dem_pending & ~w_starved;
   assign w_grant_pf  = w_idle & pf_ready & (~w_dem_pending | w_starved);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve <= '0;
      end else if (!pf_ready || w_grant_pf) begin
         r_starve <= '0;
      end else if (w_grant_dem && (r_starve != c_starve_max)) begin
         r_starve <= r_starve + c_cnt_w'(1);
      end
   end
`else
   logic w_pf_unused;

   assign w_grant_dem = w_idle & w_dem_pending;
   assign w_pf_unused = ^{pf_ready, pf_address, pf_wdata, STARVE_LIMIT[0]};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_dem) begin
               w_state_next = ST_DEMAND;
            end
`ifdef L2_ARB_PREFETCH_EN
            else if (w_grant_pf) begin
               w_state_next = ST_PREFETCH;
            end
`endif
         end
         ST_DEMAND: begin
            if (l2_resp) begin
               w_state_next = ST_IDLE;
            end
         end
`ifdef L2_ARB_PREFETCH_EN
         ST_PREFETCH: begin
            if (l2_resp) begin
               w_state_next = ST_IDLE;
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request is captured at grant so L2 never sees requester-side changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else if (w_grant_dem) begin
         r_op_write <= dem_write;
         r_addr     <= dem_address;
         r_wdata    <= dem_wdata;
      end
`ifdef L2_ARB_PREFETCH_EN
      else if (w_grant_pf) begin
         r_op_write <= 1'b1;
         r_addr     <= pf_address;
         r_wdata    <= pf_wdata;
      end
`endif
   end

   assign l2_address = r_addr;
   assign l2_wdata   = r_wdata;

   always_comb begin
      l2_read   = 1'b0;
      l2_write  = 1'b0;
      dem_resp  = 1'b0;
      dem_rdata = '0;
      pf_ack    = 1'b0;
      case (r_state)
         ST_DEMAND: begin
            l2_read   = ~r_op_write;
            l2_write  = r_op_write;
            dem_resp  = l2_resp;
            dem_rdata = l2_rdata;
         end
`ifdef L2_ARB_PREFETCH_EN
         ST_PREFETCH: begin
            l2_write = 1'b1;
            pf_ack   = l2_resp;
         end
`endif
         default: begin
            l2_read  = 1'b0;
            l2_write = 1'b0;
         end
      endcase
   end

`ifdef L2_ARB_PREFETCH_EN
   assign dont_prefetch = ~reset & ((r_state == ST_DEMAND) | (w_idle & w_dem_pending));
`else
   assign dont_prefetch = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_request_arbiter
// Purpose  : Directed bench for l2_request_arbiter; expected L2 transactions
//            are queued as requests are raised and checked when L2 is strobed.
// Revision : 1.0  initial release
// ============================================================================
module tb_l2_request_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         dem_read, dem_write, dem_resp;
   logic [15:0]  dem_address;
   logic [127:0] dem_wdata, dem_rdata;
   logic         pf_ready, pf_ack;
   logic [15:0]  pf_address;
   logic [127:0] pf_wdata;
   logic         l2_read, l2_write, l2_resp;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata, l2_rdata;
   logic         dont_prefetch;

   typedef struct {
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] data;
      logic         is_pf;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   l2_request_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .dem_read      (dem_read),
      .dem_write     (dem_write),
      .dem_address   (dem_address),
      .dem_wdata     (dem_wdata),
      .dem_resp      (dem_resp),
      .dem_rdata     (dem_rdata),
      .pf_ready      (pf_ready),
      .pf_address    (pf_address),
      .pf_wdata      (pf_wdata),
      .pf_ack        (pf_ack),
      .l2_read       (l2_read),
      .l2_write      (l2_write),
      .l2_address    (l2_address),
      .l2_wdata      (l2_wdata),
      .l2_resp       (l2_resp),
      .l2_rdata      (l2_rdata),
      .dont_prefetch (dont_prefetch)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic wr, input logic [15:0] addr, input logic [127:0] data,
                       input logic is_pf);
      exp_t e;
      e.wr = wr; e.addr = addr; e.data = data; e.is_pf = is_pf;
      sb.push_back(e);
   endtask

   // Waits for an L2 strobe, checks it against the oldest queued transaction,
   // holds it for lat cycles, then answers and checks the completion.
   task automatic serve(input string tag, input int lat, input logic [127:0] rdata,
                        input int exp_wait);
      exp_t e;
      int   waited = 0;
      while (!(l2_read || l2_write) && waited < 16) begin
         step();
         waited++;
      end
      if (exp_wait >= 0) chk({tag, "_wait"}, waited, exp_wait);
      chk({tag, "_strobe"}, l2_read | l2_write, 1'b1);
      chk({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({tag, "_op"}, {l2_read, l2_write}, e.wr ? 2'b01 : 2'b10);
      chk({tag, "_addr"}, l2_address, e.addr);
      if (e.wr) chk({tag, "_wdata"}, l2_wdata, e.data);
      for (int k = 1; k < lat; k++) begin
         step();
         chk({tag, "_hold"}, {l2_read, l2_write, l2_address}, {~e.wr, e.wr, e.addr});
      end
      l2_resp  = 1'b1;
      l2_rdata = rdata;
      #1;
      chk({tag, "_resp"}, {dem_resp, pf_ack}, e.is_pf ? 2'b01 : 2'b10);
      if (!e.is_pf && !e.wr) chk({tag, "_rdata"}, dem_rdata, rdata);
      step();
      l2_resp  = 1'b0;
      l2_rdata = '0;
      #1;
      chk({tag, "_idle"}, {l2_read, l2_write, dem_resp, pf_ack}, 4'b0000);
   endtask

   initial begin
      reset = 1'b1;
      dem_read = 1'b0; dem_write = 1'b0; dem_address = '0; dem_wdata = '0;
      pf_ready = 1'b0; pf_address = '0; pf_wdata = '0;
      l2_resp = 1'b0; l2_rdata = '0;

      // Reset state
      repeat (3) step();
      chk("rst_strobes", {l2_read, l2_write, dem_resp, pf_ack}, 4'b0000);
      chk("rst_addr", l2_address, 16'h0000);
      chk("rst_wdata", l2_wdata, 128'h0);
      chk("rst_rdata", dem_rdata, 128'h0);
`ifdef L2_ARB_PREFETCH_EN
      chk("rst_dont_pf", dont_prefetch, 1'b0);
`else
      chk("rst_dont_pf", dont_prefetch, 1'b1);
`endif
      reset = 1'b0;
      step();

      // Demand read, three-cycle L2 latency
      dem_read = 1'b1; dem_address = 16'h1230;
      push(1'b0, 16'h1230, '0, 1'b0);
      #1;
      chk("rd_c0_strobe", l2_read, 1'b0);
      chk("rd_c0_dont_pf", dont_prefetch, 1'b1);
      serve("rd1230", 3, {16{8'hA5}}, 1);
      dem_read = 1'b0;

      // Demand write; requester inputs change while L2 is busy
      dem_write = 1'b1; dem_address = 16'h2000;
      dem_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      push(1'b1, 16'h2000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
      step();
      dem_address = 16'hFFFF; dem_wdata = '1;
      #1;
      chk("wr_wdata_stable", l2_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      serve("wr2000", 2, '0, 0);
      dem_write = 1'b0;

      // Read and write together: write wins
      dem_read = 1'b1; dem_write = 1'b1; dem_address = 16'h2220; dem_wdata = {4{32'hCAFE_F00D}};
      push(1'b1, 16'h2220, {4{32'hCAFE_F00D}}, 1'b0);
      serve("rdwr2220", 1, '0, 1);
      dem_read = 1'b0; dem_write = 1'b0;

      // Reset in the middle of a demand read abandons it
      dem_read = 1'b1; dem_address = 16'h3330;
      step();
      chk("rstd_strobe", l2_read, 1'b1);
      l2_resp = 1'b1; l2_rdata = '1; reset = 1'b1;
      #1;
      chk("rstd_outs", {l2_read, l2_write, dem_resp, pf_ack}, 4'b0000);
      chk("rstd_addr", l2_address, 16'h0000);
      step();
      reset = 1'b0; l2_resp = 1'b0; l2_rdata = '0;
      #1;
      chk("rstd_no_early", l2_read, 1'b0);
      push(1'b0, 16'h3330, '0, 1'b0);
      serve("rd3330", 2, {8{16'h5A5A}}, 1);
      dem_read = 1'b0;

`ifdef L2_ARB_PREFETCH_EN
      // Demand write and prefetch raised together: demand first
      dem_write = 1'b1; dem_address = 16'h0880; dem_wdata = {2{64'h1111_2222_3333_4444}};
      pf_ready = 1'b1; pf_address = 16'h4440; pf_wdata = {8{16'hBEEF}};
      push(1'b1, 16'h0880, {2{64'h1111_2222_3333_4444}}, 1'b0);
      push(1'b1, 16'h4440, {8{16'hBEEF}}, 1'b1);
      #1;
      chk("both_dont_pf", dont_prefetch, 1'b1);
      serve("both_dem", 2, '0, 1);
      dem_write = 1'b0;
      serve("both_pf", 2, '0, 1);
      pf_ready = 1'b0;
      step();
      chk("both_single_ack", pf_ack, 1'b0);

      // Continuous demand with prefetch waiting: four demands, one prefetch
      pf_ready = 1'b1; pf_address = 16'h7700; pf_wdata = {4{32'h7777_0000}};
      dem_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dem_address = 16'h0100 + 16'(i);
         push(1'b0, 16'h0100 + 16'(i), '0, 1'b0);
         serve($sformatf("starve_d%0d", i), 2, {4{32'(i)}}, 1);
      end
      push(1'b1, 16'h7700, {4{32'h7777_0000}}, 1'b1);
      serve("starve_pf", 1, '0, 1);
      pf_ready = 1'b0; dem_address = 16'h0104;
      push(1'b0, 16'h0104, '0, 1'b0);
      serve("starve_d4", 1, {4{32'h4}}, 1);
      dem_read = 1'b0;

      // pf_ready drop and pf input changes during PREFETCH do not abort it
      pf_ready = 1'b1; pf_address = 16'h5550; pf_wdata = {16{8'h3C}};
      push(1'b1, 16'h5550, {16{8'h3C}}, 1'b1);
      step();
      pf_ready = 1'b0; pf_address = 16'hDEAD; pf_wdata = '0;
      serve("pfdrop", 3, '0, 0);

      // Reset mid-PREFETCH: no ack, request regranted after release
      pf_ready = 1'b1; pf_address = 16'h6660; pf_wdata = {16{8'h66}};
      step();
      chk("rstp_strobe", l2_write, 1'b1);
      l2_resp = 1'b1; reset = 1'b1;
      #1;
      chk("rstp_outs", {l2_read, l2_write, dem_resp, pf_ack, dont_prefetch}, 5'b00000);
      chk("rstp_wdata", l2_wdata, 128'h0);
      step();
      reset = 1'b0; l2_resp = 1'b0;
      #1;
      chk("rstp_no_early", l2_write, 1'b0);
      push(1'b1, 16'h6660, {16{8'h66}}, 1'b1);
      serve("rstp_regrant", 2, '0, 1);
      pf_ready = 1'b0;
`else
      // Prefetch path absent: pf_ready is ignored, demand unaffected
      pf_ready = 1'b1; pf_address = 16'h4440; pf_wdata = {8{16'hBEEF}};
      repeat (3) step();
      chk("nopf_write", {l2_read, l2_write}, 2'b00);
      chk("nopf_ack", pf_ack, 1'b0);
      chk("nopf_dont_pf", dont_prefetch, 1'b1);
      dem_read = 1'b1; dem_address = 16'h0990;
      push(1'b0, 16'h0990, '0, 1'b0);
      serve("nopf_dem", 2, {4{32'h0990_0990}}, 1);
      dem_read = 1'b0;
      step();
      chk("nopf_quiet", {l2_read, l2_write, pf_ack}, 3'b000);
      pf_ready = 1'b0;
`endif

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
